// File: rtl/alu_arb_pkg.sv
// Shared types and ALU opcode encodings for the shared-ALU arbiter.
package alu_arb_pkg;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } arb_state_e;

   localparam logic [3:0] ALU_OP_AND  = 4'b0000;
   localparam logic [3:0] ALU_OP_OR   = 4'b0001;
   localparam logic [3:0] ALU_OP_ADD  = 4'b0010;
   localparam logic [3:0] ALU_OP_XOR  = 4'b0011;
   localparam logic [3:0] ALU_OP_SLL  = 4'b0100;
   localparam logic [3:0] ALU_OP_SLTU = 4'b0101;
   localparam logic [3:0] ALU_OP_SUB  = 4'b0110;
   localparam logic [3:0] ALU_OP_BRU  = 4'b0111;
   localparam logic [3:0] ALU_OP_SRL  = 4'b1000;
   localparam logic [3:0] ALU_OP_SLT  = 4'b1010;
   localparam logic [3:0] ALU_OP_SRA  = 4'b1100;

endpackage

// File: rtl/alu_arb_grant.sv
// Combinational grant selection. ALU_ARB_ROUND_ROBIN_EN selects rotating-pointer
// search; otherwise fixed priority with the lowest index winning.
module alu_arb_grant #(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_valid,
   input  logic [ID_W-1:0]    ptr,
   input  logic               enable,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_idx
);

   logic [ID_W-1:0] start;
   logic            found;
   int              idx;

`ifdef ALU_ARB_ROUND_ROBIN_EN
   assign start = ptr;
`else
   logic unused_ptr;
   assign unused_ptr = ^ptr;
   assign start      = '0;
`endif

   // Walk the requesters from the start index, wrapping, and take the first valid one.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = (int'(start) + k) % NUM_REQ;
         if (enable && !found && req_valid[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = ID_W'(idx);
         end
      end
   end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one external ALU between NUM_REQ requesters and registers the result.
// Arbitration policy depends on ALU_ARB_ROUND_ROBIN_EN (fixed priority when undefined).
module alu_share_arb
   import alu_arb_pkg::*;
#(
   parameter int NUM_REQ       = 2,
   parameter int DATA_WIDTH    = 32,
   parameter int OPCODE_LENGTH = 4,
   parameter int ID_W          = $clog2(NUM_REQ)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_REQ-1:0]               req_valid,
   output logic [NUM_REQ-1:0]               req_ready,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_srca,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_srcb,
   input  logic [NUM_REQ*OPCODE_LENGTH-1:0] req_op,
   output logic [DATA_WIDTH-1:0]            alu_srca,
   output logic [DATA_WIDTH-1:0]            alu_srcb,
   output logic [OPCODE_LENGTH-1:0]         alu_op,
   input  logic [DATA_WIDTH-1:0]            alu_result,
   input  logic                             alu_blt,
   input  logic                             alu_bgt,
   input  logic                             alu_zero,
   output logic                             rsp_valid,
   input  logic                             rsp_ready,
   output logic [ID_W-1:0]                  rsp_id,
   output logic [DATA_WIDTH-1:0]            rsp_result,
   output logic                             rsp_blt,
   output logic                             rsp_bgt,
   output logic                             rsp_zero
);

   arb_state_e          state;
   logic [ID_W-1:0]     ptr;
   logic [NUM_REQ-1:0]  grant;
   logic [ID_W-1:0]     grant_idx;
   logic                can_accept;
   logic                any_grant;

   assign can_accept = (state == EMPTY) | rsp_ready;
   assign any_grant  = |grant;
   assign req_ready  = grant;

`ifndef ALU_ARB_ROUND_ROBIN_EN
   assign ptr = '0;
`endif

   alu_arb_grant #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_grant (
      .req_valid (req_valid),
      .ptr       (ptr),
      .enable    (can_accept & ~reset),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   // Idle ALU inputs are forced to zero (AND of zeros) so nothing toggles downstream.
   always_comb begin
      alu_srca = '0;
      alu_srcb = '0;
      alu_op   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            alu_srca = req_srca[i*DATA_WIDTH +: DATA_WIDTH];
            alu_srcb = req_srcb[i*DATA_WIDTH +: DATA_WIDTH];
            alu_op   = req_op[i*OPCODE_LENGTH +: OPCODE_LENGTH];
         end
      end
   end

   // A grant while FULL means the consumer drained this cycle, so refill in place.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= EMPTY;
         rsp_valid  <= 1'b0;
         rsp_id     <= '0;
         rsp_result <= '0;
         rsp_blt    <= 1'b0;
         rsp_bgt    <= 1'b0;
         rsp_zero   <= 1'b0;
`ifdef ALU_ARB_ROUND_ROBIN_EN
         ptr        <= '0;
`endif
      end else if (any_grant) begin
         state      <= FULL;
         rsp_valid  <= 1'b1;
         rsp_id     <= grant_idx;
         rsp_result <= alu_result;
         rsp_blt    <= alu_blt;
         rsp_bgt    <= alu_bgt;
         rsp_zero   <= alu_zero;
`ifdef ALU_ARB_ROUND_ROBIN_EN
         ptr        <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
`endif
      end else if (rsp_ready) begin
         state      <= EMPTY;
         rsp_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed self-checking bench for alu_share_arb with a behavioural ALU model.
module tb_alu_share_arb;
   import alu_arb_pkg::*;

`ifdef ALU_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [63:0] req_srca;
   logic [63:0] req_srcb;
   logic [7:0]  req_op;
   logic [31:0] alu_srca;
   logic [31:0] alu_srcb;
   logic [3:0]  alu_op;
   logic [31:0] alu_result;
   logic        alu_blt;
   logic        alu_bgt;
   logic        alu_zero;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [0:0]  rsp_id;
   logic [31:0] rsp_result;
   logic        rsp_blt;
   logic        rsp_bgt;
   logic        rsp_zero;

   logic        v [2];
   logic [31:0] a [2];
   logic [31:0] b [2];
   logic [3:0]  o [2];
   int          total = 0;
   int          bad   = 0;

   always #5 clk = ~clk;

   alu_share_arb dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_srca   (req_srca),
      .req_srcb   (req_srcb),
      .req_op     (req_op),
      .alu_srca   (alu_srca),
      .alu_srcb   (alu_srcb),
      .alu_op     (alu_op),
      .alu_result (alu_result),
      .alu_blt    (alu_blt),
      .alu_bgt    (alu_bgt),
      .alu_zero   (alu_zero),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_blt    (rsp_blt),
      .rsp_bgt    (rsp_bgt),
      .rsp_zero   (rsp_zero)
   );

   // Reference ALU: SUB compares signed, BRU compares unsigned
   always_comb begin
      alu_result = '0;
      alu_blt    = 1'b0;
      alu_bgt    = 1'b0;
      case (alu_op)
         ALU_OP_AND:  alu_result = alu_srca & alu_srcb;
         ALU_OP_OR:   alu_result = alu_srca | alu_srcb;
         ALU_OP_ADD:  alu_result = alu_srca + alu_srcb;
         ALU_OP_XOR:  alu_result = alu_srca ^ alu_srcb;
         ALU_OP_SLL:  alu_result = alu_srca << alu_srcb[4:0];
         ALU_OP_SLTU: alu_result = {31'b0, alu_srca < alu_srcb};
         ALU_OP_SUB: begin
            alu_result = alu_srca - alu_srcb;
            alu_blt    = $signed(alu_srca) < $signed(alu_srcb);
            alu_bgt    = $signed(alu_srca) > $signed(alu_srcb);
         end
         ALU_OP_BRU: begin
            alu_result = alu_srca - alu_srcb;
            alu_blt    = alu_srca < alu_srcb;
            alu_bgt    = alu_srca > alu_srcb;
         end
         ALU_OP_SRL:  alu_result = alu_srca >> alu_srcb[4:0];
         ALU_OP_SLT:  alu_result = {31'b0, $signed(alu_srca) < $signed(alu_srcb)};
         ALU_OP_SRA:  alu_result = $unsigned($signed(alu_srca) >>> alu_srcb[4:0]);
         default:     alu_result = '0;
      endcase
      alu_zero = (alu_result == 32'd0);
   end

   task automatic setReq(input int i, input logic val, input logic [31:0] sa,
                         input logic [31:0] sb, input logic [3:0] op);
      v[i] = val;
      a[i] = sa;
      b[i] = sb;
      o[i] = op;
   endtask

   task automatic applyStimulus(input logic rst, input logic rdy);
      reset     = rst;
      rsp_ready = rdy;
      req_valid = {v[1], v[0]};
      req_srca  = {a[1], a[0]};
      req_srcb  = {b[1], b[0]};
      req_op    = {o[1], o[0]};
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [1:0] expGrant(input int c);
      return (RR && (c % 2 == 1)) ? 2'b10 : 2'b01;
   endfunction

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [1:0] pg;
      setReq(0, 1'b0, 0, 0, ALU_OP_AND);
      setReq(1, 1'b0, 0, 0, ALU_OP_AND);
      applyStimulus(1'b1, 1'b1);
      step();

      // Reset: req_ready must stay low even with a valid request
      setReq(0, 1'b1, 32'd5, 32'd7, ALU_OP_ADD);
      applyStimulus(1'b1, 1'b1);
      sample();
      checkOutput("reset_ready", 32'(req_ready), 32'd0);
      checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("reset_rsp_result", rsp_result, 32'd0);
      checkOutput("reset_alu_op", 32'(alu_op), 32'd0);
      step();

      // Single request ADD 5+7
      applyStimulus(1'b0, 1'b1);
      sample();
      checkOutput("single_ready", 32'(req_ready), 32'd1);
      checkOutput("single_alu_srca", alu_srca, 32'd5);
      checkOutput("single_alu_op", 32'(alu_op), 32'(ALU_OP_ADD));
      step();
      setReq(0, 1'b0, 0, 0, ALU_OP_AND);
      applyStimulus(1'b0, 1'b1);
      sample();
      checkOutput("single_rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("single_rsp_id", 32'(rsp_id), 32'd0);
      checkOutput("single_rsp_result", rsp_result, 32'd12);
      checkOutput("idle_alu_srca", alu_srca, 32'd0);
      step();

      // Round robin: req0 XOR F0^0F, req1 SUB 3-3
      applyStimulus(1'b1, 1'b1);
      step();
      setReq(0, 1'b1, 32'hF0, 32'h0F, ALU_OP_XOR);
      setReq(1, 1'b1, 32'd3, 32'd3, ALU_OP_SUB);
      for (int c = 0; c < 5; c++) begin
         if (c == 4) begin
            setReq(0, 1'b0, 0, 0, ALU_OP_AND);
            setReq(1, 1'b0, 0, 0, ALU_OP_AND);
         end
         applyStimulus(1'b0, 1'b1);
         sample();
         if (c < 4) checkOutput("rr_ready", 32'(req_ready), 32'(expGrant(c)));
         if (c > 0) begin
            pg = expGrant(c - 1);
            checkOutput("rr_rsp_id", 32'(rsp_id), 32'(pg[1]));
            checkOutput("rr_rsp_result", rsp_result, pg[1] ? 32'd0 : 32'hFF);
            checkOutput("rr_rsp_zero", 32'(rsp_zero), 32'(pg[1]));
            checkOutput("rr_rsp_blt", 32'(rsp_blt), 32'd0);
         end
         step();
      end

      // Backpressure: fill with req0 ADD 1+2 while req1 SUB 10-4 waits
      setReq(0, 1'b1, 32'd1, 32'd2, ALU_OP_ADD);
      setReq(1, 1'b1, 32'd10, 32'd4, ALU_OP_SUB);
      applyStimulus(1'b0, 1'b0);
      sample();
      checkOutput("bp_first_ready", 32'(req_ready), 32'd1);
      step();
      setReq(0, 1'b0, 0, 0, ALU_OP_AND);
      for (int c = 0; c < 4; c++) begin
         applyStimulus(1'b0, 1'b0);
         sample();
         checkOutput("bp_hold_ready", 32'(req_ready), 32'd0);
         checkOutput("bp_hold_valid", 32'(rsp_valid), 32'd1);
         checkOutput("bp_hold_result", rsp_result, 32'd3);
         step();
      end
      applyStimulus(1'b0, 1'b1);
      sample();
      checkOutput("bp_drain_ready", 32'(req_ready), 32'd2);
      checkOutput("bp_drain_result", rsp_result, 32'd3);
      step();
      setReq(1, 1'b0, 0, 0, ALU_OP_AND);
      applyStimulus(1'b0, 1'b1);
      sample();
      checkOutput("bp_refill_valid", 32'(rsp_valid), 32'd1);
      checkOutput("bp_refill_id", 32'(rsp_id), 32'd1);
      checkOutput("bp_refill_result", rsp_result, 32'd6);
      step();

      // Flags: signed SUB then unsigned BRU on FFFFFFFF vs 1
      setReq(0, 1'b1, 32'hFFFF_FFFF, 32'd1, ALU_OP_SUB);
      applyStimulus(1'b0, 1'b1);
      step();
      setReq(0, 1'b1, 32'hFFFF_FFFF, 32'd1, ALU_OP_BRU);
      applyStimulus(1'b0, 1'b1);
      sample();
      checkOutput("sub_blt", 32'(rsp_blt), 32'd1);
      checkOutput("sub_bgt", 32'(rsp_bgt), 32'd0);
      checkOutput("sub_result", rsp_result, 32'hFFFF_FFFE);
      step();
      setReq(0, 1'b0, 0, 0, ALU_OP_AND);
      applyStimulus(1'b0, 1'b1);
      sample();
      checkOutput("bru_bgt", 32'(rsp_bgt), 32'd1);
      checkOutput("bru_blt", 32'(rsp_blt), 32'd0);
      step();

      // Reset mid-operation with a response pending
      setReq(0, 1'b1, 32'd2, 32'd2, ALU_OP_ADD);
      applyStimulus(1'b0, 1'b0);
      step();
      setReq(0, 1'b0, 0, 0, ALU_OP_AND);
      applyStimulus(1'b0, 1'b0);
      sample();
      checkOutput("mid_full_valid", 32'(rsp_valid), 32'd1);
      checkOutput("mid_full_result", rsp_result, 32'd4);
      step();
      setReq(0, 1'b1, 32'd8, 32'd1, ALU_OP_ADD);
      setReq(1, 1'b1, 32'd9, 32'd1, ALU_OP_ADD);
      applyStimulus(1'b1, 1'b1);
      sample();
      checkOutput("mid_reset_ready", 32'(req_ready), 32'd0);
      step();
      applyStimulus(1'b0, 1'b1);
      sample();
      checkOutput("post_reset_valid", 32'(rsp_valid), 32'd0);
      checkOutput("post_reset_result", rsp_result, 32'd0);
      checkOutput("post_reset_ready", 32'(req_ready), 32'd1);
      step();
      applyStimulus(1'b0, 1'b1);
      sample();
      checkOutput("post_reset_rsp_id", 32'(rsp_id), 32'd0);
      checkOutput("post_reset_rsp_result", rsp_result, 32'd9);
      checkOutput("post_reset_second_ready", 32'(req_ready), 32'(expGrant(1)));
      step();

      // Sustained contention for 8 grants
      applyStimulus(1'b1, 1'b1);
      step();
      for (int c = 0; c < 8; c++) begin
         applyStimulus(1'b0, 1'b1);
         sample();
         checkOutput("prio_ready", 32'(req_ready), 32'(expGrant(c)));
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Arbiter and sequencer that shares one combinational ALU between `NUM_REQ` requesters (e.g. execute stage, branch unit, address generator). Each requester presents operands and an opcode under a valid/ready handshake. The block grants one requester per cycle, drives the ALU, and captures the result plus branch flags into a single-entry response register tagged with the requester ID. It sits between the requesters and the shared `alu` instance, which is instantiated outside this block.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters, 2..8.
- `DATA_WIDTH`, default 32: operand and result width.
- `OPCODE_LENGTH`, default 4: ALU operation code width.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the response tag.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester valid.
- `req_ready`  out  NUM_REQ  per-requester accept; one-hot or zero.
- `req_srca`  in  NUM_REQ*DATA_WIDTH  operand A; requester i occupies slice i.
- `req_srcb`  in  NUM_REQ*DATA_WIDTH  operand B; requester i occupies slice i.
- `req_op`  in  NUM_REQ*OPCODE_LENGTH  ALU opcode; requester i occupies slice i.
- `alu_srca`, `alu_srcb`  out  DATA_WIDTH  operands to the shared ALU.
- `alu_op`  out  OPCODE_LENGTH  operation to the shared ALU.
- `alu_result`  in  DATA_WIDTH  ALU result.
- `alu_blt`, `alu_bgt`, `alu_zero`  in  1  ALU branch flags.
- `rsp_valid`  out  1  response register holds data.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  ID_W  index of the requester that owns the response.
- `rsp_result`  out  DATA_WIDTH  registered ALU result.
- `rsp_blt`, `rsp_bgt`, `rsp_zero`  out  1  registered branch flags.

## Operation
- FSM has two states:
  - `EMPTY`: response register invalid.
  - `FULL`: response register valid.
- Accept condition: `can_accept = (state==EMPTY) | rsp_ready`.
  - A grant is issued only when `can_accept` is 1 and `reset` is 0.
- Grant: exactly one valid requester `g` is selected. `req_ready[g]=1` in the same cycle, combinationally. The handshake completes when valid and ready are both high.
- ALU drive: `alu_srca`, `alu_srcb` and `alu_op` are combinationally muxed from requester `g`. With no grant they are all zero (opcode `4'b0000`, AND).
- On the edge after a grant, the response register loads:
  - `rsp_result` and flags from the ALU,
  - `rsp_id=g`,
  - `rsp_valid=1`.
- Transitions:
  - EMPTY to FULL on a grant.
  - FULL to EMPTY on `rsp_ready` with no grant.
  - FULL stays FULL on `rsp_ready` with a simultaneous grant (drain and refill in the same cycle).
  - FULL stays FULL holding its data when `rsp_ready=0`.
- While FULL and `rsp_ready=0`: all `req_ready=0`, and response outputs are stable.
- Requesters must hold `req_valid` and their operands stable until accepted. The block does not latch unaccepted requests.
- Arbitration order: a rotating pointer `ptr` (ID_W bits).
  - Search order is `ptr`, `ptr+1`, …, wrapping modulo NUM_REQ.
  - After a grant to `g`, `ptr` becomes `(g+1) mod NUM_REQ`.
  - `ptr` is unchanged when there is no grant.
- Fairness: a continuously valid requester is granted within NUM_REQ accepted transactions.
- Flags are passed through unmodified. They are meaningful only for opcodes `4'b0110` and `4'b0111`.

## Timing
- Request-to-response latency: 1 cycle. `rsp_valid` rises on the edge following the handshake.
- Throughput: 1 transaction per cycle while `rsp_ready` is held high.
- Reset values (synchronous, applied on any edge with `reset=1`, including mid-transaction):
  - state EMPTY, `ptr=0`,
  - `rsp_valid=0`, `rsp_id=0`, `rsp_result=0`,
  - `rsp_blt=0`, `rsp_bgt=0`, `rsp_zero=0`.
- A response pending at reset is discarded.
- `req_ready` is 0 throughout any cycle in which `reset=1`.
- No combinational path from `rsp_ready` to `rsp_*` outputs. The path from `rsp_ready` to `req_ready` is combinational by design.

## Configuration
- `ALU_ARB_ROUND_ROBIN_EN` defined: rotating-pointer arbitration as described above.
- Not defined: fixed priority, where the lowest index wins. The `ptr` register and its update logic are removed. Starvation of high-index requesters is permitted.
- All other behaviour is identical in both builds.

## Structure
- Package `alu_arb_pkg` holds:
  - the `arb_state_e` enum (`EMPTY`, `FULL`),
  - opcode localparams `ALU_OP_AND`=0000, `OR`=0001, `ADD`=0010, `XOR`=0011, `SLL`=0100, `SLTU`=0101, `SUB`=0110, `BRU`=0111, `SRL`=1000, `SLT`=1010, `SRA`=1100.
- Sub-module `alu_arb_grant`: purely combinational. Inputs are `req_valid`, `ptr` and `enable`; output is the one-hot grant plus encoded index. It contains the macro-dependent logic.
- The top level holds the FSM, `ptr`, the operand mux and the response register.

## Test plan
- **Reset / single request:** reset, then req0 with ADD 5+7, `rsp_ready=1`. Expect:
  - `req_ready=01` in the same cycle,
  - next cycle `rsp_valid=1`, `rsp_id=0`, `rsp_result=12`.
- **Round robin:** both requesters valid continuously (req0 XOR, req1 SUB 3-3), `rsp_ready=1`.
  - Grants alternate 0,1,0,1.
  - req1 responses show `rsp_zero=1`, `rsp_blt=0`.
- **Backpressure:** `rsp_ready=0` with the response FULL and req1 valid.
  - `req_ready=00` and response outputs held for 4 cycles.
  - When `rsp_ready=1`, drain and accept req1 in the same cycle; the next cycle shows req1's result.
- **Signed/unsigned flags:** SUB 0xFFFFFFFF vs 1 gives `rsp_blt=1`. Branch-unsigned (`4'b0111`) 0xFFFFFFFF vs 1 gives `rsp_bgt=1`.
- **Reset mid-operation:** response FULL with `rsp_ready=0`, then assert `reset` for 1 cycle.
  - Next cycle `rsp_valid=0`, `ptr=0`.
  - Subsequent simultaneous req0/req1 grants req0 first.
- **Macro off:** without `ALU_ARB_ROUND_ROBIN_EN`, with req0 and req1 continuously valid, req0 wins on 8 consecutive grants.
